prm_edge_scan_seq: RTL and testbench



---
 rtl/prm_scan_pkg.sv | 27 ++
 rtl/prm_mask_reduce.sv | 15 +
 rtl/prm_edge_scan_seq.sv | 193 +++++++++++++++++++
 tb/tb_prm_edge_scan_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_scan_pkg.sv
// Shared types and helpers for the edge scan sequencer.
// Feature macro used by the top: PRM_SCAN_BLOCKCNT_EN (per-scan blocked-code counter).
package prm_scan_pkg;

    localparam int unsigned CODE_W     = 15;
    localparam int unsigned DEF_WORD_W = 32;
    localparam int unsigned DEF_AW     = 12;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } scan_state_e;

    // Bit position of a code inside its output word; word_w must be a power of two.
    function automatic logic [CODE_W-1:0] code_to_bitpos(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] lo,
        input int unsigned       word_w
    );
        logic [CODE_W-1:0] diff;
        diff = code - lo;
        return diff & CODE_W'(word_w - 1);
    endfunction

endpackage

// File: rtl/prm_mask_reduce.sv
// AND-then-OR reduction of checker masks against the enabled obstacle set.
// Kept separate so a pipelined reduction tree can replace it without touching the sequencer.
module prm_mask_reduce #(
    parameter int unsigned NUM_OBS = 1024
) (
    input  logic [NUM_OBS-1:0] mask,
    input  logic [NUM_OBS-1:0] en,
    output logic               blk
);

    always_comb begin
        blk = |(mask & en);
    end

endmodule

// File: rtl/prm_edge_scan_seq.sv
// Sweeps an edge-code range through the obstacle checkers and streams packed blocked bits.
// Optional blk_count output is enabled with `define PRM_SCAN_BLOCKCNT_EN.
module prm_edge_scan_seq
    import prm_scan_pkg::*;
#(
    parameter int unsigned NUM_OBS = 1024,
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned AW      = DEF_AW
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [CODE_W-1:0]   range_lo,
    input  logic [CODE_W-1:0]   range_hi,
    input  logic [NUM_OBS-1:0]  obs_en,
    output logic [CODE_W-1:0]   chk_code,
    input  logic [NUM_OBS-1:0]  chk_mask,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [WORD_W-1:0]   word_data,
    output logic [AW-1:0]       word_addr,
    output logic                busy,
    output logic                done
`ifdef PRM_SCAN_BLOCKCNT_EN
    ,
    output logic [15:0]         blk_count
`endif
);

    localparam int unsigned BPW = $clog2(WORD_W);

    scan_state_e          state_q, state_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [CODE_W-1:0]    lo_q, lo_d;
    logic [CODE_W-1:0]    hi_q, hi_d;
    logic [NUM_OBS-1:0]   obs_en_q, obs_en_d;
    logic [WORD_W-1:0]    pack_q, pack_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 valid_q, valid_d;

    logic                 blk;
    logic [BPW-1:0]       bitpos;
    logic                 is_last;
    logic                 is_full;
    logic                 move_due;
    logic                 out_free;
    logic                 advance;
    logic                 accept;
    logic [WORD_W-1:0]    pack_new;

    prm_mask_reduce #(
        .NUM_OBS (NUM_OBS)
    ) u_reduce (
        .mask (chk_mask),
        .en   (obs_en_q),
        .blk  (blk)
    );

    always_comb begin
        bitpos   = BPW'(code_to_bitpos(code_q, lo_q, WORD_W));
        is_last  = (code_q == hi_q);
        is_full  = (bitpos == BPW'(WORD_W - 1));
        move_due = is_last || is_full;
        accept   = valid_q && word_ready;
        out_free = !valid_q || word_ready;
        // A bit is only committed when its word can actually leave, otherwise it is re-sampled.
        advance  = (state_q == SCAN) && (!move_due || out_free);
        pack_new = pack_q;
        pack_new[bitpos] = blk;
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        obs_en_d = obs_en_q;
        pack_d   = pack_q;
        idx_d    = idx_q;
        data_d   = data_q;
        addr_d   = addr_q;
        valid_d  = valid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = range_lo;
                    hi_d     = range_hi;
                    obs_en_d = obs_en;
                    code_d   = range_lo;
                    pack_d   = '0;
                    idx_d    = '0;
                    state_d  = (range_lo <= range_hi) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (accept) begin
                    valid_d = 1'b0;
                end
                if (advance) begin
                    if (move_due) begin
                        data_d  = pack_new;
                        addr_d  = idx_q;
                        idx_d   = idx_q + AW'(1);
                        valid_d = 1'b1;
                        pack_d  = '0;
                    end else begin
                        pack_d  = pack_new;
                    end
                    // Never step past range_hi, so 0x7FFF terminates without wrapping.
                    if (is_last) begin
                        state_d = FLUSH;
                    end else begin
                        code_d  = code_q + CODE_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            code_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            obs_en_q <= '0;
            pack_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            obs_en_q <= obs_en_d;
            pack_q   <= pack_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
        end
    end

`ifdef PRM_SCAN_BLOCKCNT_EN
    logic [15:0] blkcnt_q, blkcnt_d;

    always_comb begin
        blkcnt_d = blkcnt_q;
        if (state_q == IDLE && start) begin
            blkcnt_d = '0;
        end else if (advance && blk) begin
            blkcnt_d = blkcnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blkcnt_q <= '0;
        end else begin
            blkcnt_q <= blkcnt_d;
        end
    end

    assign blk_count = blkcnt_q;
`else
    // Block counter not built.
`endif

    assign chk_code   = code_q;
    assign word_valid = valid_q;
    assign word_data  = data_q;
    assign word_addr  = addr_q;
    assign busy       = (state_q == SCAN) || (state_q == FLUSH);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// Scoreboard bench for prm_edge_scan_seq with two modelled obstacle checkers.
module tb_prm_edge_scan_seq;

    localparam int unsigned NUM_OBS = 2;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned AW      = 12;

    typedef struct {
        logic [AW-1:0]     addr;
        logic [WORD_W-1:0] data;
    } word_t;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [14:0]       range_lo;
    logic [14:0]       range_hi;
    logic [1:0]        obs_en;
    logic [14:0]       chk_code;
    logic [1:0]        chk_mask;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic [AW-1:0]     word_addr;
    logic              busy;
    logic              done;
`ifdef PRM_SCAN_BLOCKCNT_EN
    logic [15:0]       blk_count;
`endif

    int          tests = 0;
    int          fails = 0;
    word_t       exp_q[$];
    int          mode = 0;
    logic [31:0] key = 32'h1;
    int          ready_mode = 0;
    int          low_left = 0;
    int          done_cnt = 0;
    bit          busy_seen = 0;
    int          stall_cnt = 0;
    logic [14:0] stall_code = '0;
    logic [14:0] lat_lo = '0;
    logic [14:0] lat_hi = '0;
    int          exp_blk = 0;

    prm_edge_scan_seq #(
        .NUM_OBS (NUM_OBS),
        .WORD_W  (WORD_W),
        .AW      (AW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .range_lo   (range_lo),
        .range_hi   (range_hi),
        .obs_en     (obs_en),
        .chk_code   (chk_code),
        .chk_mask   (chk_mask),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .busy       (busy),
        .done       (done)
`ifdef PRM_SCAN_BLOCKCNT_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    // Behaviour of the two obstacle checkers for each stimulus mode.
    function automatic logic [1:0] mask_fn(input logic [14:0] code, input int md,
                                           input logic [31:0] k);
        logic [31:0] h;
        h = {17'b0, code} * k;
        h = h ^ (h >> 11);
        case (md)
            0:       return {code[1], code[0]};
            1:       return {code[2], 1'b1};
            2:       return {code == 15'h7FFF, 1'b0};
            default: return {h[19], h[12]};
        endcase
    endfunction

    assign chk_mask = mask_fn(chk_code, mode, key);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Ready driver.
    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0: word_ready = 1'b1;
                1: word_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (low_left > 0) begin
                        word_ready = 1'b0;
                        low_left--;
                    end else begin
                        word_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: handshake stability, code walk and scoreboard pops.
    initial begin
        word_t             e;
        bit                prev_valid, prev_ready, prev_busy;
        logic [WORD_W-1:0] prev_data;
        logic [AW-1:0]     prev_addr;
        logic [14:0]       prev_code;
        prev_valid = 0; prev_ready = 0; prev_busy = 0;
        prev_data = '0; prev_addr = '0; prev_code = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_valid = 0;
                prev_busy  = 0;
            end else begin
                if (done) done_cnt++;
                if (busy) busy_seen = 1;
                if (prev_valid && !prev_ready) begin
                    check(word_valid == 1'b1, "valid_held", 32'(word_valid), 32'd1);
                    check(word_data == prev_data, "data_stable", word_data, prev_data);
                    check(word_addr == prev_addr, "addr_stable", 32'(word_addr),
                          32'(prev_addr));
                end
                if (busy) begin
                    check(chk_code >= lat_lo && chk_code <= lat_hi, "code_in_range",
                          32'(chk_code), 32'(lat_hi));
                    if (prev_busy) begin
                        check(chk_code == prev_code || chk_code == prev_code + 15'd1,
                              "code_step", 32'(chk_code), 32'(prev_code));
                        if (prev_valid && !prev_ready && chk_code == prev_code) begin
                            stall_cnt++;
                            stall_code = chk_code;
                        end
                    end
                end
                if (word_valid && word_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_word", word_data, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check(word_addr == e.addr, "word_addr", 32'(word_addr), 32'(e.addr));
                        check(word_data == e.data, "word_data", word_data, e.data);
                    end
                end
                prev_valid = word_valid;
                prev_ready = word_ready;
                prev_busy  = busy;
                prev_data  = word_data;
                prev_addr  = word_addr;
                prev_code  = chk_code;
            end
        end
    end

    task automatic pulse_start(input logic [14:0] lo, input logic [14:0] hi,
                               input logic [1:0] en);
        @(posedge CLK);
        #1;
        range_lo = lo;
        range_hi = hi;
        obs_en   = en;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        // Only the latched enable mask may matter from here on.
        obs_en   = 2'($urandom);
    endtask

    task automatic run_scan(input logic [14:0] lo, input logic [14:0] hi, input logic [1:0] en,
                            input int md, input int rmode, input int lowc);
        int          n;
        int          budget;
        int          k;
        logic [31:0] w;
        word_t       item;
        logic [14:0] c;
        bit          b;
        n = int'(hi) - int'(lo) + 1;
        exp_blk = 0;
        w = '0;
        for (int i = 0; i < n; i++) begin
            c = 15'(int'(lo) + i);
            b = |(mask_fn(c, md, key) & en);
            if (b) exp_blk++;
            w[i % WORD_W] = b;
            if ((i % WORD_W) == WORD_W - 1 || i == n - 1) begin
                item.addr = AW'(i / WORD_W);
                item.data = w;
                exp_q.push_back(item);
                w = '0;
            end
        end
        mode       = md;
        lat_lo     = lo;
        lat_hi     = hi;
        done_cnt   = 0;
        busy_seen  = 0;
        stall_cnt  = 0;
        low_left   = lowc;
        ready_mode = rmode;
        pulse_start(lo, hi, en);
        budget = (n > 0) ? 4 * n + lowc + 200 : 20;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check(done_cnt != 0, "done_timeout", 32'(k), 32'(budget));
        if (n <= 0) begin
            check(k <= 2, "empty_done_latency", 32'(k), 32'd2);
        end
        repeat (3) @(negedge CLK);
        #1;
        check(done_cnt == 1, "done_pulses", 32'(done_cnt), 32'd1);
        check(exp_q.size() == 0, "words_left", 32'(exp_q.size()), 32'd0);
        check(busy == 1'b0, "busy_after_done", 32'(busy), 32'd0);
        if (n <= 0) begin
            check(busy_seen == 1'b0, "empty_busy", 32'(busy_seen), 32'd0);
        end
`ifdef PRM_SCAN_BLOCKCNT_EN
        check(blk_count == 16'(exp_blk), "blk_count", 32'(blk_count), 32'(exp_blk));
`endif
        exp_q.delete();
        ready_mode = 0;
    endtask

    initial begin
        logic [14:0] lo;
        logic [14:0] hi;
        int          j;
        RST_N    = 1'b0;
        start    = 1'b0;
        range_lo = '0;
        range_hi = '0;
        obs_en   = '0;
        #12;
        check(chk_code == 15'd0, "reset_chk_code", 32'(chk_code), 32'd0);
        check(word_valid == 1'b0, "reset_valid", 32'(word_valid), 32'd0);
        check(word_data == '0, "reset_data", word_data, 32'd0);
        check(word_addr == '0, "reset_addr", 32'(word_addr), 32'd0);
        check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        check(done == 1'b0, "reset_done", 32'(done), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Odd codes blocked on checker0: one word 0xAAAAAAAA.
        run_scan(15'd0, 15'd31, 2'b01, 0, 0, 0);
        // Empty range.
        run_scan(15'd5, 15'd4, 2'b01, 0, 0, 0);
        // All blocked, consumer stalls: scan must hold on the last code.
        run_scan(15'd0, 15'd39, 2'b01, 1, 2, 60);
        check(stall_cnt > 0, "stall_seen", 32'(stall_cnt), 32'd1);
        check(stall_code == 15'd39, "stall_code", 32'(stall_code), 32'd39);
        // Top of the code space.
        run_scan(15'h7FE0, 15'h7FFF, 2'b10, 2, 0, 0);
        // Random ready on the first scenario.
        run_scan(15'd0, 15'd31, 2'b01, 0, 1, 0);

        // Asynchronous reset mid-scan.
        mode = 0; lat_lo = 15'd0; lat_hi = 15'd63; ready_mode = 0;
        pulse_start(15'd0, 15'd63, 2'b01);
        j = 0;
        while (chk_code != 15'd17 && j < 100) begin
            @(negedge CLK);
            j++;
        end
        check(chk_code == 15'd17, "reach_code17", 32'(chk_code), 32'd17);
        #2;
        RST_N = 1'b0;
        #1;
        check(chk_code == 15'd0, "areset_chk_code", 32'(chk_code), 32'd0);
        check(word_valid == 1'b0, "areset_valid", 32'(word_valid), 32'd0);
        check(word_data == '0, "areset_data", word_data, 32'd0);
        check(word_addr == '0, "areset_addr", 32'(word_addr), 32'd0);
        check(busy == 1'b0, "areset_busy", 32'(busy), 32'd0);
        check(done == 1'b0, "areset_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        run_scan(15'd0, 15'd31, 2'b01, 0, 0, 0);

        // Randomized scans.
        for (int t = 0; t < 10; t++) begin
            key = $urandom | 32'h1;
            lo  = 15'($urandom_range(0, 32'h7FFF));
            hi  = (int'(lo) + 150 > 32'h7FFF) ? 15'h7FFF : 15'(int'(lo) + $urandom_range(0, 150));
            run_scan(lo, hi, 2'($urandom), 3, 1, 0);
        end

        // Full code space.
        key = $urandom | 32'h1;
        run_scan(15'h0000, 15'h7FFF, 2'b11, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
